// File: rtl/joy_autoread.sv
// ---------------------------------------------------------------------------
// joy_autoread
//
// Automatic joypad reader. A START pulse (gated by ENABLE) begins one read:
// JOY_STRB is held high to latch both controllers, then 16 serial clock
// pulses shift out 16 bits per data line. Each bit is sampled just before the
// falling edge of its serial clock, inverted (pressed = 1) and shifted into a
// shadow register MSB-first. When the read finishes, all shadows are copied
// to the JOY*_DATA outputs in the same cycle and DONE pulses for one cycle.
//
// Parameters
//   STRB_CYCLES  JOY_STRB high time in CLK cycles (>= 2)
//   BIT_CYCLES   one full serial-clock period in CLK cycles (even, >= 4)
//
// Ports
//   CLK                 in   system clock, rising edge
//   RESET_N             in   asynchronous active-low reset
//   ENABLE              in   auto-read enable; START ignored while low
//   START               in   one-cycle read request
//   JOY_STRB            out  controller latch, active-high
//   JOY1_CLK, JOY2_CLK  out  serial clocks, idle high, identical
//   JOY1_DI, JOY2_DI    in   serial data [1:0], active-low
//   BUSY                out  read in progress
//   DONE                out  one-cycle pulse when results commit
//   JOY1..JOY4_DATA     out  results (JOY3/JOY4 from DI[1])
//
// Configuration
//   JOY_MULTITAP_EN  when defined, JOY3_DATA/JOY4_DATA are captured from
//                    JOY1_DI[1]/JOY2_DI[1]; otherwise they are constant 0.
//
// All pin outputs are registered from the next state so the controller
// lines never see decode glitches.
// ---------------------------------------------------------------------------
module joy_autoread #(
    parameter int STRB_CYCLES = 256,
    parameter int BIT_CYCLES  = 256
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        ENABLE,
    input  logic        START,
    output logic        JOY_STRB,
    output logic        JOY1_CLK,
    output logic        JOY2_CLK,
    input  logic [1:0]  JOY1_DI,
    input  logic [1:0]  JOY2_DI,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] JOY1_DATA,
    output logic [15:0] JOY2_DATA,
    output logic [15:0] JOY3_DATA,
    output logic [15:0] JOY4_DATA
);

    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int MAX_CYCLES  = (STRB_CYCLES > HALF_CYCLES) ? STRB_CYCLES : HALF_CYCLES;
    // Counter holds at most MAX_CYCLES-1 (counts down to zero).
    localparam int CNT_W       = $clog2(MAX_CYCLES);

    localparam logic [CNT_W-1:0] STRB_LOAD = CNT_W'(STRB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        CLK_LO = 3'd2,
        CLK_HI = 3'd3,
        COMMIT = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [3:0]       bit_q, bit_d;
    logic             sample;

    logic             strb_q;
    logic             jclk_q;
    logic             busy_q;
    logic             done_q;

    logic [15:0]      sh1_q;
    logic [15:0]      sh2_q;
    logic [15:0]      data1_q;
    logic [15:0]      data2_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        sample  = 1'b0;

        case (state_q)
            IDLE: begin
                if (START && ENABLE) begin
                    state_d = LATCH;
                    phase_d = STRB_LOAD;
                    bit_d   = 4'd0;
                end
            end

            LATCH: begin
                if (phase_q == '0) begin
                    // Bit 0 is valid while the strobe is still high.
                    sample  = 1'b1;
                    state_d = CLK_LO;
                    phase_d = HALF_LOAD;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end

            CLK_LO: begin
                if (phase_q == '0) begin
                    state_d = CLK_HI;
                    phase_d = HALF_LOAD;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end

            CLK_HI: begin
                if (phase_q == '0) begin
                    if (bit_q == 4'd15) begin
                        // Sixteenth pulse done: all bits already captured.
                        state_d = COMMIT;
                        phase_d = '0;
                        bit_d   = 4'd0;
                    end else begin
                        sample  = 1'b1;
                        state_d = CLK_LO;
                        phase_d = HALF_LOAD;
                        bit_d   = bit_q + 4'd1;
                    end
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end

            COMMIT: begin
                state_d = IDLE;
                phase_d = '0;
                bit_d   = 4'd0;
            end

            default: begin
                state_d = IDLE;
                phase_d = '0;
                bit_d   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, counters and registered pin outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            phase_q <= '0;
            bit_q   <= 4'd0;
            strb_q  <= 1'b0;
            jclk_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            strb_q  <= (state_d == LATCH);
            jclk_q  <= (state_d != CLK_LO);
            busy_q  <= (state_d == LATCH) || (state_d == CLK_LO) || (state_d == CLK_HI);
            done_q  <= (state_d == COMMIT);
        end
    end

    // ------------------------------------------------------------------
    // Shadow capture and atomic commit (ports 1 and 2)
    // Data is loaded on the edge entering COMMIT so it is visible in the
    // same cycle that DONE is high.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sh1_q   <= '0;
            sh2_q   <= '0;
            data1_q <= '0;
            data2_q <= '0;
        end else begin
            if (sample) begin
                sh1_q <= {sh1_q[14:0], ~JOY1_DI[0]};
                sh2_q <= {sh2_q[14:0], ~JOY2_DI[0]};
            end
            if (state_d == COMMIT) begin
                data1_q <= sh1_q;
                data2_q <= sh2_q;
            end
        end
    end

`ifdef JOY_MULTITAP_EN
    logic [15:0] sh3_q;
    logic [15:0] sh4_q;
    logic [15:0] data3_q;
    logic [15:0] data4_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sh3_q   <= '0;
            sh4_q   <= '0;
            data3_q <= '0;
            data4_q <= '0;
        end else begin
            if (sample) begin
                sh3_q <= {sh3_q[14:0], ~JOY1_DI[1]};
                sh4_q <= {sh4_q[14:0], ~JOY2_DI[1]};
            end
            if (state_d == COMMIT) begin
                data3_q <= sh3_q;
                data4_q <= sh4_q;
            end
        end
    end

    assign JOY3_DATA = data3_q;
    assign JOY4_DATA = data4_q;
`else
    // Multitap lines are not read in this build.
    logic unused_di;
    assign unused_di = JOY1_DI[1] ^ JOY2_DI[1];

    assign JOY3_DATA = 16'h0000;
    assign JOY4_DATA = 16'h0000;
`endif

    assign JOY_STRB  = strb_q;
    assign JOY1_CLK  = jclk_q;
    assign JOY2_CLK  = jclk_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign JOY1_DATA = data1_q;
    assign JOY2_DATA = data2_q;

endmodule

// File: tb/tb_joy_autoread.sv
// ---------------------------------------------------------------------------
// tb_joy_autoread
//
// Directed bench for joy_autoread with STRB_CYCLES = 4, BIT_CYCLES = 4.
// Each controller is modelled as a 16-bit shift register that reloads its
// button pattern while JOY_STRB is high and shifts left on every rising edge
// of its serial clock; the line carries the inverted MSB (active-low).
// Cycle 0 of a read is the cycle in which START is high.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_joy_autoread;

    localparam int STRB_CYCLES = 4;
    localparam int BIT_CYCLES  = 4;

    logic        CLK;
    logic        RESET_N;
    logic        ENABLE;
    logic        START;
    logic        JOY_STRB;
    logic        JOY1_CLK;
    logic        JOY2_CLK;
    logic [1:0]  JOY1_DI;
    logic [1:0]  JOY2_DI;
    logic        BUSY;
    logic        DONE;
    logic [15:0] JOY1_DATA;
    logic [15:0] JOY2_DATA;
    logic [15:0] JOY3_DATA;
    logic [15:0] JOY4_DATA;

    joy_autoread #(
        .STRB_CYCLES (STRB_CYCLES),
        .BIT_CYCLES  (BIT_CYCLES)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .ENABLE    (ENABLE),
        .START     (START),
        .JOY_STRB  (JOY_STRB),
        .JOY1_CLK  (JOY1_CLK),
        .JOY2_CLK  (JOY2_CLK),
        .JOY1_DI   (JOY1_DI),
        .JOY2_DI   (JOY2_DI),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .JOY1_DATA (JOY1_DATA),
        .JOY2_DATA (JOY2_DATA),
        .JOY3_DATA (JOY3_DATA),
        .JOY4_DATA (JOY4_DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Controller models: pressed buttons are 1 in the pattern.
    logic [15:0] pat1a, pat2a, pat1b, pat2b;
    logic [15:0] m1a, m2a, m1b, m2b;

    always @(posedge CLK) begin
        if (JOY_STRB) begin
            m1a <= pat1a;
            m2a <= pat2a;
            m1b <= pat1b;
            m2b <= pat2b;
        end
    end

    always @(posedge JOY1_CLK) begin
        if (!JOY_STRB) begin
            m1a <= {m1a[14:0], 1'b0};
            m1b <= {m1b[14:0], 1'b0};
        end
    end

    always @(posedge JOY2_CLK) begin
        if (!JOY_STRB) begin
            m2a <= {m2a[14:0], 1'b0};
            m2b <= {m2b[14:0], 1'b0};
        end
    end

    assign JOY1_DI = {~m1b[15], ~m1a[15]};
    assign JOY2_DI = {~m2b[15], ~m2a[15]};

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Per-run observations
    int r_strb_n, r_strb_first, r_strb_last;
    int r_done_n, r_done_c, r_falls, r_busy_bad, r_clk_bad;

    // Runs ncyc cycles, sampling outputs mid-cycle, then driving START for
    // the cycles st/re1/re2 and dropping ENABLE from cycle en_drop onward.
    task automatic run_read(input int ncyc, input int st, input int re1,
                            input int re2, input int en_drop);
        logic prev_clk;
        prev_clk     = 1'b1;
        r_strb_n     = 0;
        r_strb_first = -1;
        r_strb_last  = -1;
        r_done_n     = 0;
        r_done_c     = -1;
        r_falls      = 0;
        r_busy_bad   = 0;
        r_clk_bad    = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge CLK);
            if (JOY_STRB) begin
                r_strb_n++;
                if (r_strb_first < 0) r_strb_first = c;
                r_strb_last = c;
            end
            if (DONE) begin
                r_done_n++;
                r_done_c = c;
            end
            if (prev_clk && !JOY1_CLK) r_falls++;
            prev_clk = JOY1_CLK;
            if (JOY1_CLK !== JOY2_CLK) r_clk_bad++;
            if (BUSY !== ((c >= 1) && (c <= 68))) r_busy_bad++;
            ENABLE = (en_drop >= 0 && c >= en_drop) ? 1'b0 : 1'b1;
            START  = (c == st || c == re1 || c == re2) ? 1'b1 : 1'b0;
        end
        START  = 1'b0;
        ENABLE = 1'b1;
    endtask

    logic [15:0] exp3, exp4;
    int          bad;

    initial begin
        RESET_N = 1'b0;
        ENABLE  = 1'b1;
        START   = 1'b0;
        pat1a   = 16'h0000;
        pat2a   = 16'h0000;
        pat1b   = 16'h0000;
        pat2b   = 16'h0000;

        // Reset state
        repeat (3) @(negedge CLK);
        check_eq("rst_strb", 32'(JOY_STRB), 32'd0);
        check_eq("rst_clks", 32'({JOY1_CLK, JOY2_CLK}), 32'd3);
        check_eq("rst_busy_done", 32'({BUSY, DONE}), 32'd0);
        check_eq("rst_data12", {JOY1_DATA, JOY2_DATA}, 32'h0000_0000);
        check_eq("rst_data34", {JOY3_DATA, JOY4_DATA}, 32'h0000_0000);
        RESET_N = 1'b1;

        // 100 idle cycles without START
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK);
            if (JOY_STRB !== 1'b0 || JOY1_CLK !== 1'b1 || JOY2_CLK !== 1'b1 ||
                BUSY !== 1'b0 || DONE !== 1'b0 ||
                {JOY1_DATA, JOY2_DATA, JOY3_DATA, JOY4_DATA} !== 64'd0) bad++;
        end
        check_eq("idle_100", 32'(bad), 32'd0);

        // Read 1: port-1 0x8001, port-2 released
        pat1a = 16'h8001; pat2a = 16'h0000; pat1b = 16'h1234; pat2b = 16'hABCD;
`ifdef JOY_MULTITAP_EN
        exp3 = 16'h1234; exp4 = 16'hABCD;
`else
        exp3 = 16'h0000; exp4 = 16'h0000;
`endif
        run_read(80, 0, -1, -1, -1);
        check_eq("r1_strb_n", 32'(r_strb_n), 32'd4);
        check_eq("r1_strb_first", 32'(r_strb_first), 32'd1);
        check_eq("r1_strb_last", 32'(r_strb_last), 32'd4);
        check_eq("r1_done_n", 32'(r_done_n), 32'd1);
        check_eq("r1_done_cyc", 32'(r_done_c), 32'd69);
        check_eq("r1_low_pulses", 32'(r_falls), 32'd16);
        check_eq("r1_busy", 32'(r_busy_bad), 32'd0);
        check_eq("r1_clk_match", 32'(r_clk_bad), 32'd0);
        check_eq("r1_joy1", 32'(JOY1_DATA), 32'h8001);
        check_eq("r1_joy2", 32'(JOY2_DATA), 32'h0000);
        check_eq("r1_joy3", 32'(JOY3_DATA), 32'(exp3));
        check_eq("r1_joy4", 32'(JOY4_DATA), 32'(exp4));

        // Read 2: all port-2 buttons pressed, START re-pulsed mid-read,
        // ENABLE dropped from cycle 20
        pat1a = 16'h5AC3; pat2a = 16'hFFFF; pat1b = 16'hFFFF; pat2b = 16'h0001;
`ifdef JOY_MULTITAP_EN
        exp3 = 16'hFFFF; exp4 = 16'h0001;
`else
        exp3 = 16'h0000; exp4 = 16'h0000;
`endif
        run_read(80, 0, 10, 40, 20);
        check_eq("r2_strb_n", 32'(r_strb_n), 32'd4);
        check_eq("r2_done_n", 32'(r_done_n), 32'd1);
        check_eq("r2_done_cyc", 32'(r_done_c), 32'd69);
        check_eq("r2_low_pulses", 32'(r_falls), 32'd16);
        check_eq("r2_busy", 32'(r_busy_bad), 32'd0);
        check_eq("r2_joy1", 32'(JOY1_DATA), 32'h5AC3);
        check_eq("r2_joy2", 32'(JOY2_DATA), 32'hFFFF);
        check_eq("r2_joy3", 32'(JOY3_DATA), 32'(exp3));
        check_eq("r2_joy4", 32'(JOY4_DATA), 32'(exp4));

        // START while ENABLE low is ignored; data holds
        @(negedge CLK);
        ENABLE = 1'b0;
        START  = 1'b1;
        @(negedge CLK);
        START  = 1'b0;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (JOY_STRB !== 1'b0 || BUSY !== 1'b0) bad++;
        end
        ENABLE = 1'b1;
        check_eq("en_low_ignored", 32'(bad), 32'd0);
        check_eq("hold_joy1", 32'(JOY1_DATA), 32'h5AC3);

        // Read 3: reset at cycle 30
        pat1a = 16'hFFFF; pat2a = 16'h1111;
        run_read(30, 0, -1, -1, -1);
        check_eq("r3_strb_n", 32'(r_strb_n), 32'd4);
        @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        check_eq("r3_rst_strb", 32'(JOY_STRB), 32'd0);
        check_eq("r3_rst_clks", 32'({JOY1_CLK, JOY2_CLK}), 32'd3);
        check_eq("r3_rst_busy_done", 32'({BUSY, DONE}), 32'd0);
        check_eq("r3_rst_data12", {JOY1_DATA, JOY2_DATA}, 32'h0000_0000);
        check_eq("r3_rst_data34", {JOY3_DATA, JOY4_DATA}, 32'h0000_0000);
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        run_read(80, -1, -1, -1, -1);
        check_eq("r3_no_done", 32'(r_done_n), 32'd0);
        check_eq("r3_no_strb", 32'(r_strb_n), 32'd0);

        // Read 4: normal read after the aborted one
        pat1a = 16'h0F0F; pat2a = 16'h00F0; pat1b = 16'h8000; pat2b = 16'h0003;
`ifdef JOY_MULTITAP_EN
        exp3 = 16'h8000; exp4 = 16'h0003;
`else
        exp3 = 16'h0000; exp4 = 16'h0000;
`endif
        run_read(80, 0, -1, -1, -1);
        check_eq("r4_done_n", 32'(r_done_n), 32'd1);
        check_eq("r4_done_cyc", 32'(r_done_c), 32'd69);
        check_eq("r4_busy", 32'(r_busy_bad), 32'd0);
        check_eq("r4_joy1", 32'(JOY1_DATA), 32'h0F0F);
        check_eq("r4_joy2", 32'(JOY2_DATA), 32'h00F0);
        check_eq("r4_joy3", 32'(JOY3_DATA), 32'(exp3));
        check_eq("r4_joy4", 32'(JOY4_DATA), 32'(exp4));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/joy_autoread.md
JOY_AUTOREAD -- requirements
Module: joy_autoread

Interface
REQ-001 SHALL have parameter STRB_CYCLES, default 256: JOY_STRB high time in CLK cycles (>=2).
REQ-002 SHALL have parameter BIT_CYCLES, default 256: one full serial-clock period in CLK cycles (even, >=4).
REQ-003 SHALL have port CLK  in  1  system clock (MCLK domain); all logic on rising edge.
REQ-004 SHALL have port RESET_N  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port ENABLE  in  1  auto-read enable; START is ignored while low.
REQ-006 SHALL have port START  in  1  one-cycle request to begin a read (vblank-start pulse).
REQ-007 SHALL have port JOY_STRB  out  1  latch to both ports, active-high.
REQ-008 SHALL have ports JOY1_CLK, JOY2_CLK  out  1 each  serial clocks, idle high, identical waveforms.
REQ-009 SHALL have ports JOY1_DI, JOY2_DI  in  2 each  serial data, active-low (0 = pressed).
REQ-010 SHALL have port BUSY  out  1  high while a read is in progress.
REQ-011 SHALL have port DONE  out  1  one-cycle pulse when results commit.
REQ-012 SHALL have ports JOY1_DATA..JOY4_DATA  out  16 each  results: JOY1 = JOY1_DI[0], JOY2 = JOY2_DI[0], JOY3 = JOY1_DI[1], JOY4 = JOY2_DI[1].

Function
REQ-013 SHALL implement states IDLE, LATCH, CLK_LO, CLK_HI, COMMIT.
REQ-014 IDLE -> LATCH on START & ENABLE; JOY_STRB high for exactly STRB_CYCLES cycles, starting the cycle after START.
REQ-015 LATCH -> CLK_LO, CLK_LO -> CLK_HI, CLK_HI -> CLK_LO (next bit); each phase lasts BIT_CYCLES/2 cycles; JOY*_CLK low only in CLK_LO.
REQ-016 Exactly 16 low pulses per read; after the 16th CLK_HI the FSM enters COMMIT for one cycle, then IDLE.
REQ-017 DI sampled once per bit, in the last cycle of LATCH (bit 0) or of CLK_HI (bits 1-15), i.e. just before each falling edge.
REQ-018 Sampled bit inverted (pressed = 1) and shifted into an internal shadow register MSB-first: shadow <= {shadow[14:0], ~DI}.
REQ-019 JOY*_DATA updated from shadows only in COMMIT (atomic); DONE high in COMMIT; outputs hold between commits.
REQ-020 BUSY high from the first LATCH cycle through the last CLK_HI cycle; low in COMMIT and IDLE.
REQ-021 Total duration START to DONE = 1 + STRB_CYCLES + 16*BIT_CYCLES cycles.
REQ-022 START while not IDLE SHALL be ignored (no restart, no queuing).
REQ-023 ENABLE falling mid-read SHALL NOT abort; the read completes and commits.
REQ-024 Phase/bit counters SHALL wrap only via FSM reload; bit counter 4-bit, never exceeds 15.

Reset
REQ-025 RESET_N low asynchronously forces IDLE, JOY_STRB = 0, JOY1_CLK = JOY2_CLK = 1, BUSY = 0, DONE = 0, all JOY*_DATA = 0, shadows = 0, counters = 0.
REQ-026 Reset mid-read discards partial data; no DONE is produced for the aborted read.

Configuration
REQ-027 Macro JOY_MULTITAP_EN defined: JOY3_DATA and JOY4_DATA are captured from DI[1] per REQ-012.
REQ-028 Macro JOY_MULTITAP_EN undefined: DI[1] inputs ignored, JOY3_DATA and JOY4_DATA are constant 0, their shadow logic is absent; all other behaviour is identical.

Verification (bench: STRB_CYCLES = 4, BIT_CYCLES = 4, controller model shifts on JOY_CLK rising edge, reloads on JOY_STRB)
REQ-029 Reset release, no START -> JOY_STRB = 0, CLKs = 1, BUSY = 0, all data = 0x0000 for 100 cycles.
REQ-030 Port-1 model pattern 0x8001 (DI[0] active-low), START at cycle 0 -> STRB cycles 1-4, 16 low pulses, DONE at cycle 69, JOY1_DATA = 0x8001.
REQ-031 Port-2 all buttons released -> JOY2_DATA = 0x0000; all pressed -> 0xFFFF.
REQ-032 START re-pulsed at cycles 10 and 40 of a read -> single DONE at cycle 69, no extra STRB.
REQ-033 RESET_N low at cycle 30 -> outputs at reset values immediately, no DONE; a new START afterwards completes normally.
REQ-034 With JOY_MULTITAP_EN, DI[1] patterns 0x1234/0xABCD -> JOY3_DATA = 0x1234, JOY4_DATA = 0xABCD; without it, both read 0x0000.
